// File: rtl/mux_rr_arb_pkg.sv
// Shared definitions for the round-robin 8:1 mux arbiter: FSM encoding,
// channel geometry and hold-counter sizing.
package arb_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    localparam int MAX_HOLD_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // A hold limit of 1 would give a zero-width counter; keep at least one bit.
    function automatic int hold_w(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Request/grant bundle between the mux clients (master) and the arbiter (slave).
interface mux_rr_arb_if;
    import arb_pkg::*;

    logic [N_CH-1:0]  req;
    logic             done;
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             tout;

    modport master (
        output req, done,
        input  gnt, sel, en, tout
    );

    modport slave (
        input  req, done,
        output gnt, sel, en, tout
    );

endinterface

// File: rtl/mux_rr_arb_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr,
// wrapping modulo the channel count.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit overwrites last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = ptr_i + SEL_W'(k);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// Round-robin arbiter for a shared 8:1 mux with a per-grant hold limit and a
// one-cycle break-before-make gap between owners.
module mux_rr_arb
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mux_rr_arb_if.slave  bus
);

    // state    | meaning
    // ST_IDLE  | no owner; arbitrate every cycle
    // ST_GRANT | one channel owns the mux; hold_cnt counts its cycles
    // ST_GAP   | one-cycle dead time after a release; arbitrates like IDLE

    localparam int HOLD_W = hold_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic [N_CH-1:0]  gnt_q,   gnt_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             en_q,    en_d;
    logic             tout_q,  tout_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;
    logic             at_limit;
    logic             release_now;

    rr_pick u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign owner_req   = bus.req[sel_q];
    assign at_limit    = (hold_q == HOLD_LAST);
    assign release_now = bus.done || !owner_req || at_limit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        tout_d  = 1'b0;

        case (state_q)
            ST_GRANT: begin
                if (release_now) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    en_d    = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                    // A timeout only counts when nothing else would have released.
                    tout_d  = at_limit && !bus.done && owner_req;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
                    sel_d   = pick_idx;
                    en_d    = 1'b1;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    en_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            tout_q  <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            tout_q  <= tout_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.tout = tout_q;

endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum number of consecutive cycles one requester may own the shared 8:1 mux.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  request per channel; req[i] asks that mux input a[i] be routed to y.
REQ-005 done  input  1  the current owner releases; ignored when no grant is active.
REQ-006 gnt  output  8  one-hot grant, or all-zero; registered.
REQ-007 sel  output  3  mux select (binary index of the owner); registered.
REQ-008 en  output  1  mux enable; high exactly while gnt is non-zero; registered.
REQ-009 tout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-010 FSM states are IDLE, GRANT and GAP.
REQ-011 Round-robin pointer ptr (3 bit): the search starts at ptr and ascends modulo 8; the first i with req[i]=1 wins.
REQ-012 IDLE with req!=0: the next edge enters GRANT with gnt[i]=1, sel=i, en=1, hold_cnt=0 (grant latency: 1 cycle).
REQ-013 IDLE with req=0: stay in IDLE; gnt=0, en=0, sel keeps its last value.
REQ-014 GRANT: hold_cnt increments each cycle; the grant holds while req[owner]=1, done=0 and hold_cnt<MAX_HOLD-1.
REQ-015 GRANT release occurs on any of: done=1, req[owner]=0, or hold_cnt=MAX_HOLD-1. The next edge applies all of:
- gnt=0 and en=0;
- ptr=(owner+1) mod 8;
- state=GAP.
REQ-016 A grant therefore lasts at most MAX_HOLD cycles.
REQ-017 tout=1 for the single cycle after release only if the release was caused by the hold limit with done=0 and req[owner]=1.
REQ-018 When done and the hold limit coincide, exactly one release occurs and tout stays 0.
REQ-019 GAP lasts exactly one cycle with en=0 (break-before-make). GAP arbitrates exactly as IDLE does: GRANT if req!=0, else IDLE.
REQ-020 Release-to-next-grant latency is exactly 2 edges, leaving one idle cycle on the mux.
REQ-021 A sole persistent requester is regranted after the GAP cycle; the hold limit does not lock it out.
REQ-022 Requests raised or dropped during GRANT do not affect the current owner, other than the owner's own req.
REQ-023 ptr wraps from 7 to 0.
REQ-024 gnt is never multi-hot.
REQ-025 sel always equals the index of the set gnt bit whenever en=1.

Reset
REQ-026 While rst=1, without waiting for clk: state=IDLE, gnt=0, sel=0, en=0, tout=0, ptr=0, hold_cnt=0.
REQ-027 Reset asserted mid-grant drops the grant immediately; no tout pulse is produced.
REQ-028 After rst deasserts, the first arbitration starts from channel 0.

Structure
REQ-029 Shared package arb_pkg holds:
- FSM state encoding (IDLE, GRANT, GAP);
- channel count 8 and select width 3;
- hold counter width $clog2(MAX_HOLD).
REQ-030 A combinational sub-module rr_pick takes req and ptr and returns valid plus a 3-bit index. The main block holds the FSM, the counter and the output registers.

Verification
REQ-031 After reset, req=8'h01 -> next cycle gnt=8'h01, sel=0, en=1.
REQ-032 req=8'hFF held, done=1 in every GRANT cycle -> grants 0,1,2,...,7,0 in order, each separated by one en=0 cycle.
REQ-033 MAX_HOLD=4, req=8'h08 held, done=0 -> gnt=8'h08 for 4 cycles, then one GAP cycle with tout=1 and en=0, then gnt=8'h08 again.
REQ-034 With ptr=5 and req=8'h90 -> grant channel 7; after done, grant channel 4 (wrap through 0).
REQ-035 Owner req drops mid-grant -> gnt=0 on the next edge, ptr=owner+1, tout=0.
REQ-036 rst pulsed mid-grant (req=8'h20) -> gnt=0, en=0, sel=0 asynchronously. After release with req=8'h21, grant channel 0 first.
